niosbase_debug_ocimem_master: RTL
=================================

// Module: niosbase_debug_ocimem_master
// PURPOSE
//  Debug memory-access engine directly downstream of the debug-slave wrapper's sysclk stage.
//  - Consumes jdo and the take_*_ocimem_* strobes.
//  - Runs single-word Avalon-MM reads/writes on behalf of the JTAG host.
//  - Returns MonDReg, monitor_ready and monitor_error to the debug-slave tck stage.
// PARAMETERS
//  ADDR_W      16   word-address width; byte address = {MonAReg,2'b00}
//  TIMEOUT     255  max cycles a transfer may stall on waitrequest before abort (1..2^TO_W-1)
//  TO_W        8    timeout counter width
// PORTS
//  clk                      in   1       system clock
//  reset_n                  in   1       asynchronous active-low reset
//  jdo                      in   38      JTAG data from sysclk stage, valid with strobes
//  take_action_ocimem_a     in   1       1-cycle strobe: load address
//  take_action_ocimem_b     in   1       1-cycle strobe: write word
//  take_no_action_ocimem_a  in   1       1-cycle strobe: read next word
//  MonDReg                  out  32      read/write data register
//  monitor_ready            out  1       1 = engine idle, last command complete
//  monitor_error            out  1       sticky: timeout or command-while-busy
//  dbg_address              out  ADDR_W+2  Avalon byte address
//  dbg_read                 out  1       Avalon read
//  dbg_write                out  1       Avalon write
//  dbg_writedata            out  32      = MonDReg
//  dbg_byteenable           out  4       constant 4'hF
//  dbg_waitrequest          in   1       Avalon stall
//  dbg_readdata             in   32      valid in the cycle dbg_read=1 and waitrequest=0
// BEHAVIOUR
//  Reset (async, any state):
//  - MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, dbg_read=dbg_write=0, state=IDLE.
//  - Outputs drop in the same instant, not at the next edge.
//  States:
//  - IDLE -> RD on read strobe, or on address load with jdo[35]=1.
//  - IDLE -> WR on write strobe.
//  - RD/WR -> IDLE when waitrequest=0, or on timeout.
//  Strobe decode (IDLE only):
//  - Priority b > a > no_action when strobes coincide; the losers are dropped, no error.
//  - ocimem_a: MonAReg <= jdo[ADDR_W+1:2]; monitor_error <= 0; if jdo[35], start read next cycle.
//  - ocimem_b: MonDReg <= jdo[34:3]; start write.
//  - no_action_ocimem_a: start read.
//  Timing:
//  - Strobe on edge N -> dbg_read/dbg_write high from N+1, monitor_ready low from N+1.
//  - Read and write strobes are held until waitrequest=0 (no pipelining).
//  - Completion edge: reads capture MonDReg <= dbg_readdata.
//  - Completion edge: MonAReg <= MonAReg+1, modulo 2^ADDR_W (0x..FFFF wraps to 0).
//  - Completion edge: dbg_read/dbg_write drop and monitor_ready returns to 1 at the next edge.
//  - Zero-wait access: ready low for exactly 1 cycle.
//  Timeout:
//  - Counter clears on entry to RD/WR and counts each cycle waitrequest=1.
//  - At count==TIMEOUT: abort, deassert read/write, monitor_error <= 1.
//  - Also on timeout: MonDReg unchanged, MonAReg still increments so the host can skip a dead word.
//  Busy:
//  - Any strobe while state!=IDLE is ignored and sets monitor_error.
//  - A simultaneous completion takes effect normally.
//  Error:
//  - monitor_error is sticky; cleared only by an address load or reset.
//  - An address load that hits while busy sets the error instead of clearing it.
//  Output rules:
//  - dbg_read and dbg_write are never both 1.
//  - dbg_address = {MonAReg,2'b00}, stable while the transfer is held.
// TESTING
//  1. Reset, then addr load jdo[17:2]=16'h0010 with jdo[35]=1, readdata=32'hCAFEF00D, wait=0
//     -> read at byte 0x0040 one cycle later; MonDReg=CAFEF00D; MonAReg=0x0011; ready low 1 cycle.
//  2. Write strobe jdo[34:3]=32'h12345678 with waitrequest high 3 cycles
//     -> dbg_write held 4 cycles, writedata=12345678, address increments once.
//  3. waitrequest stuck high -> abort after 255 stall cycles, monitor_error=1, MonDReg unchanged;
//     a following addr load clears the error.
//  4. MonAReg=16'hFFFF, read -> dbg_address=0x3FFFC, then MonAReg=0.
//  5. Read strobe while busy -> ignored, monitor_error=1. Coincident a+b in IDLE -> write only.
//  6. reset_n low mid-RD with waitrequest high -> dbg_read=0 immediately, all regs at reset values.

Source files
------------

// File: rtl/niosbase_debug_ocimem_master_if.sv
// Avalon-MM debug bus between the OCI memory engine (master) and the
// system interconnect (slave).
//   dbg_address     byte address {word, 2'b00}
//   dbg_read/write  single-word transfer request, held until waitrequest=0
//   dbg_writedata   write word
//   dbg_byteenable  byte lanes
//   dbg_waitrequest slave stall
//   dbg_readdata    read word, valid when read=1 and waitrequest=0
interface niosbase_debug_ocimem_master_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W+1:0] dbg_address;
  logic              dbg_read;
  logic              dbg_write;
  logic [31:0]       dbg_writedata;
  logic [3:0]        dbg_byteenable;
  logic              dbg_waitrequest;
  logic [31:0]       dbg_readdata;

  modport master (
    output dbg_address, dbg_read, dbg_write, dbg_writedata, dbg_byteenable,
    input  dbg_waitrequest, dbg_readdata
  );

  modport slave (
    input  dbg_address, dbg_read, dbg_write, dbg_writedata, dbg_byteenable,
    output dbg_waitrequest, dbg_readdata
  );
endinterface

// File: rtl/niosbase_debug_ocimem_master.sv
// Debug memory-access engine. Decodes the JTAG host's OCI memory strobes
// and runs single-word Avalon reads/writes, returning the data word, a
// ready flag and a sticky error flag to the debug-slave tck stage.
//   clk, reset_n              system clock, async active-low reset
//   jdo                       host data, valid with the strobes
//   take_action_ocimem_a      load address (jdo[35]=1 also starts a read)
//   take_action_ocimem_b      load data word and write it
//   take_no_action_ocimem_a   read next word
//   MonDReg                   data register (read result / write data)
//   monitor_ready             1 = idle, last command complete
//   monitor_error             sticky: timeout or command while busy
//   dbg                       Avalon-MM master port
module niosbase_debug_ocimem_master #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  niosbase_debug_ocimem_master_if.master dbg
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  // The counter holds the stalls already seen; a stall cycle that finds it
  // at TIMEOUT-1 is the TIMEOUT-th stall and aborts on that edge.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] mon_a;
  logic [TO_W-1:0]   stall_cnt;
  logic              rd_q, wr_q;
  logic              any_strobe;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  assign dbg.dbg_address    = {mon_a, 2'b00};
  assign dbg.dbg_read       = rd_q;
  assign dbg.dbg_write      = wr_q;
  assign dbg.dbg_writedata  = MonDReg;
  assign dbg.dbg_byteenable = 4'hF;

  // jdo bits outside the address and data fields carry other commands.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mon_a         <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      stall_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // b wins over a, a over no_action; losers are silently dropped
          if (take_action_ocimem_b) begin
            MonDReg       <= jdo[34:3];
            state         <= WR;
            wr_q          <= 1'b1;
            monitor_ready <= 1'b0;
            stall_cnt     <= '0;
          end else if (take_action_ocimem_a) begin
            mon_a         <= jdo[ADDR_W+1:2];
            monitor_error <= 1'b0;
            if (jdo[35]) begin
              state         <= RD;
              rd_q          <= 1'b1;
              monitor_ready <= 1'b0;
              stall_cnt     <= '0;
            end
          end else if (take_no_action_ocimem_a) begin
            state         <= RD;
            rd_q          <= 1'b1;
            monitor_ready <= 1'b0;
            stall_cnt     <= '0;
          end
        end
        default: begin
          // Commands while busy are dropped and flagged; an address load
          // here must not clear the error, so no clear path exists here.
          if (any_strobe) monitor_error <= 1'b1;
          if (!dbg.dbg_waitrequest || stall_cnt == TO_LAST) begin
            if (dbg.dbg_waitrequest)
              monitor_error <= 1'b1;            // timeout abort
            else if (state == RD)
              MonDReg <= dbg.dbg_readdata;
            // advance even on abort so the host can step past a dead word
            mon_a         <= mon_a + ADDR_W'(1);
            state         <= IDLE;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            monitor_ready <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + TO_W'(1);
          end
        end
      endcase
    end
  end

endmodule
